// File: rtl/match_priority_encoder_if.sv
// rtl/match_priority_encoder_if.sv - lookup-in / result-out bundle of the match priority encoder
interface match_priority_encoder_if #(
  parameter int D     = 512,
  parameter int CNT_W = 32
);
  localparam int AW = $clog2(D);

  logic             in_valid;
  logic [D-1:0]     match;
  logic             out_valid;
  logic             match_found;
  logic [AW-1:0]    match_addr;
  logic             multi_match;
  logic [CNT_W-1:0] lookup_cnt;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output in_valid, match,
    input  out_valid, match_found, match_addr, multi_match, lookup_cnt, hit_cnt
  );

  modport slave (
    input  in_valid, match,
    output out_valid, match_found, match_addr, multi_match, lookup_cnt, hit_cnt
  );
endinterface

// File: rtl/match_priority_encoder.sv
// rtl/match_priority_encoder.sv - 3-stage lowest-index match encoder with saturating counters
// Optional multi-match detection is built when MULTI_MATCH_EN is defined.
module match_priority_encoder #(
  parameter int D     = 512,
  parameter int CNT_W = 32
) (
  input logic                     clk,
  input logic                     reset,
  match_priority_encoder_if.slave bus
);
  localparam int AW = $clog2(D);
  localparam int G  = D / 8;
  localparam int GW = AW - 3;

  logic             s1_valid;
  logic [D-1:0]     s1_match;
  logic             s2_valid;
  logic [G-1:0]     grp_any, grp_any_c;
  logic [G-1:0][2:0] grp_idx, grp_idx_c;
  logic             s3_valid, s3_found, s3_multi;
  logic [AW-1:0]    s3_addr;
  logic [CNT_W-1:0] lookup_cnt, hit_cnt;
  logic             found_c, multi_c;
  logic [AW-1:0]    addr_c;
  logic [GW-1:0]    sel_g;

  // Per-group OR and lowest set bit; descending scan leaves the lowest index last.
  always_comb begin
    grp_any_c = '0;
    grp_idx_c = '0;
    for (int g = 0; g < G; g++) begin
      grp_any_c[g] = |s1_match[8*g +: 8];
      for (int b = 7; b >= 0; b--) begin
        if (s1_match[8*g + b]) grp_idx_c[g] = 3'(b);
      end
    end
  end

  always_comb begin
    sel_g = '0;
    for (int g = G - 1; g >= 0; g--) begin
      if (grp_any[g]) sel_g = GW'(g);
    end
    found_c = |grp_any;
    addr_c  = {sel_g, grp_idx[sel_g]};
  end

`ifdef MULTI_MATCH_EN
  logic [G-1:0] grp_multi, grp_multi_c;

  // x & (x-1) clears the lowest set bit; nonzero remainder means two or more bits.
  always_comb begin
    grp_multi_c = '0;
    for (int g = 0; g < G; g++) begin
      grp_multi_c[g] = (s1_match[8*g +: 8] & (s1_match[8*g +: 8] - 8'd1)) != 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) grp_multi <= '0;
    else       grp_multi <= grp_multi_c;
  end

  assign multi_c = (|grp_multi) || ((grp_any & (grp_any - G'(1))) != '0);
`else
  assign multi_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_match   <= '0;
      s2_valid   <= 1'b0;
      grp_any    <= '0;
      grp_idx    <= '0;
      s3_valid   <= 1'b0;
      s3_found   <= 1'b0;
      s3_addr    <= '0;
      s3_multi   <= 1'b0;
      lookup_cnt <= '0;
      hit_cnt    <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_match <= bus.match;
      s2_valid <= s1_valid;
      grp_any  <= grp_any_c;
      grp_idx  <= grp_idx_c;
      s3_valid <= s2_valid;
      s3_found <= found_c;
      s3_addr  <= addr_c;
      s3_multi <= multi_c;
      // Counters update on the same edge the result is registered, so they agree with out_valid.
      if (s2_valid) begin
        if (lookup_cnt != '1)            lookup_cnt <= lookup_cnt + CNT_W'(1);
        if (found_c && (hit_cnt != '1))  hit_cnt    <= hit_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid   = s3_valid;
  assign bus.match_found = s3_found;
  assign bus.match_addr  = s3_addr;
  assign bus.multi_match = s3_multi;
  assign bus.lookup_cnt  = lookup_cnt;
  assign bus.hit_cnt     = hit_cnt;
endmodule
